pc_fetch_ctrl: RTL and testbench

- Program-counter and fetch-sequencing stage for the RISC-V core.
- Owns the PC register and issues instruction-fetch requests over a ready handshake.
- Consumes the 3-bit branch-compare flags that the ALU produces for a SUB, plus decoded control, and resolves the next PC for sequential, conditional branch, JAL and JALR flow.
- Detects misaligned jump/branch targets and halts.

---
 rtl/pc_fetch_ctrl_if.sv | 22 ++
 rtl/pc_fetch_ctrl.sv | 135 +++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-fetch handshake between pc_fetch_ctrl and instruction memory.
//   if_req   : fetch request, held high while waiting for the word
//   if_addr  : word address being fetched (tracks the controller's pc)
//   if_ready : memory presents the word for if_addr this cycle
// master = fetch controller, slave = instruction memory.
interface pc_fetch_ctrl_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;

  modport master (
    output if_req,
    output if_addr,
    input  if_ready
  );

  modport slave (
    input  if_req,
    input  if_addr,
    output if_ready
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Program-counter and fetch-sequencing stage for the RISC-V core.
// Owns the PC, fetches over a ready handshake, then holds the instruction in
// EXEC while the branch/jump outcome is resolved into the next PC.
// A taken redirect to a non-word-aligned target halts until reset.
//   clk, rst_n   : core clock (rising edge), async active-low reset
//   fetch        : instruction-fetch handshake (if_req/if_addr/if_ready)
//   stall        : hold the current instruction in EXEC
//   npc_op       : next-PC operation (SEQ/BEQ/BNE/BLT/BGE/JAL/JALR)
//   branch_flag  : ALU compare flags {a>b, a<b, a==b}, one-hot when legal
//   imm          : sign-extended B/J offset
//   jalr_base    : rs1+imm from the ALU for JALR
//   pc, pc_plus4 : current PC and its link value
//   exec_valid   : instruction held in EXEC
//   taken        : EXEC instruction redirects the PC (combinational)
//   misalign     : sticky misaligned-redirect indicator
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pc_fetch_ctrl_if.master        fetch,
  input  logic                   stall,
  input  logic [2:0]             npc_op,
  input  logic [2:0]             branch_flag,
  input  logic [31:0]            imm,
  input  logic [31:0]            jalr_base,
  output logic [31:0]            pc,
  output logic [31:0]            pc_plus4,
  output logic                   exec_valid,
  output logic                   taken,
  output logic                   misalign
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    OP_SEQ  = 3'b000,
    OP_BEQ  = 3'b001,
    OP_BNE  = 3'b010,
    OP_BLT  = 3'b011,
    OP_BGE  = 3'b100,
    OP_JAL  = 3'b101,
    OP_JALR = 3'b110,
    OP_RSVD = 3'b111
  } npc_op_t;

  typedef enum logic [2:0] {
    FLAG_EQ = 3'b001,
    FLAG_LT = 3'b010,
    FLAG_GT = 3'b100
  } flag_t;

  state_t      state;
  logic        if_req_q;
  logic        cond_hit;
  logic [31:0] target;
  logic [31:0] next_pc;
  logic        bad_target;

  assign pc_plus4      = pc + 32'd4;
  assign fetch.if_req  = if_req_q;
  assign fetch.if_addr = pc;

  // Illegal (non one-hot) flag codes match none of the compares, which makes
  // BNE taken and BGE not taken.
  always_comb begin
    cond_hit = 1'b0;
    case (npc_op)
      OP_BEQ:          cond_hit = (branch_flag == FLAG_EQ);
      OP_BNE:          cond_hit = (branch_flag != FLAG_EQ);
      OP_BLT:          cond_hit = (branch_flag == FLAG_LT);
      OP_BGE:          cond_hit = (branch_flag == FLAG_EQ) || (branch_flag == FLAG_GT);
      OP_JAL, OP_JALR: cond_hit = 1'b1;
      default:         cond_hit = 1'b0;
    endcase
  end

  // JALR clears only bit 0, so bit 1 can still produce a misaligned target.
  assign target     = (npc_op == OP_JALR) ? (jalr_base & 32'hFFFF_FFFE) : (pc + imm);
  assign taken      = (state == EXEC) && cond_hit;
  assign next_pc    = taken ? target : pc_plus4;
  assign bad_target = taken && (target[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BOOT;
      pc         <= RESET_PC;
      if_req_q   <= 1'b0;
      exec_valid <= 1'b0;
      misalign   <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state    <= FETCH;
          if_req_q <= 1'b1;
        end
        FETCH: begin
          if (fetch.if_ready) begin
            state      <= EXEC;
            if_req_q   <= 1'b0;
            exec_valid <= 1'b1;
          end
        end
        EXEC: begin
          if (!stall) begin
            exec_valid <= 1'b0;
            if (bad_target) begin
              misalign <= 1'b1;
              state    <= HALT;
            end else begin
              pc       <= next_pc;
              if_req_q <= 1'b1;
              state    <= FETCH;
            end
          end
        end
        HALT: begin
          if_req_q   <= 1'b0;
          exec_valid <= 1'b0;
        end
        default: begin
          state      <= HALT;
          if_req_q   <= 1'b0;
          exec_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic [2:0]  npc_op = 3'd0;
  logic [2:0]  branch_flag = 3'd0;
  logic [31:0] imm = '0;
  logic [31:0] jalr_base = '0;
  logic [31:0] pc, pc_plus4;
  logic        exec_valid, taken, misalign;

  pc_fetch_ctrl_if fif ();

  pc_fetch_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch       (fif.master),
    .stall       (stall),
    .npc_op      (npc_op),
    .branch_flag (branch_flag),
    .imm         (imm),
    .jalr_base   (jalr_base),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .exec_valid  (exec_valid),
    .taken       (taken),
    .misalign    (misalign)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: phase 0 boot, 1 waiting for a word, 2 instruction held, 3 halted.
  int          m_ph  = 0;
  logic [31:0] m_pc  = RST_PC;
  logic        m_mis = 1'b0;

  function automatic logic m_cond(input logic [2:0] op, input logic [2:0] f);
    logic eq, lt, gt;
    eq = (f == 3'b001);
    lt = (f == 3'b010);
    gt = (f == 3'b100);
    case (op)
      3'd1:       return eq;
      3'd2:       return !eq;
      3'd3:       return lt;
      3'd4:       return eq || gt;
      3'd5, 3'd6: return 1'b1;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_target(input logic [2:0] op, input logic [31:0] cur,
                                           input logic [31:0] off, input logic [31:0] base);
    if (op == 3'd6) return (base >> 1) << 1;
    return cur + off;
  endfunction

  function automatic logic m_taken();
    return (m_ph == 2) && m_cond(npc_op, branch_flag);
  endfunction

  task automatic model_update();
    logic [31:0] t;
    case (m_ph)
      0: m_ph = 1;
      1: if (fif.if_ready) m_ph = 2;
      2: if (!stall) begin
           if (m_taken()) begin
             t = m_target(npc_op, m_pc, imm, jalr_base);
             if (t % 4 != 0) begin
               m_mis = 1'b1;
               m_ph  = 3;
             end else begin
               m_pc = t;
               m_ph = 1;
             end
           end else begin
             m_pc = m_pc + 32'd4;
             m_ph = 1;
           end
         end
      default: m_ph = 3;
    endcase
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("pc",         pc,                 m_pc);
    chk("pc_plus4",   pc_plus4,           m_pc + 32'd4);
    chk("if_req",     32'(fif.if_req),    32'(m_ph == 1));
    chk("if_addr",    fif.if_addr,        m_pc);
    chk("exec_valid", 32'(exec_valid),    32'(m_ph == 2));
    chk("taken",      32'(taken),         32'(m_taken()));
    chk("misalign",   32'(misalign),      32'(m_mis));
  endtask

  // Caller drives inputs first; outputs checked, then one clock edge taken.
  task automatic cycle();
    #1;
    check_all();
    @(posedge clk);
    if (rst_n) model_update();
    #1;
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    m_ph  = 0;
    m_pc  = RST_PC;
    m_mis = 1'b0;
    #1;
    chk("rst_pc",       pc,                 RST_PC);
    chk("rst_misalign", 32'(misalign),      32'd0);
    chk("rst_if_req",   32'(fif.if_req),    32'd0);
    chk("rst_exec",     32'(exec_valid),    32'd0);
  endtask

  task automatic reset_cycle();
    assert_reset();
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic run_to_exec();
    npc_op = 3'd0; stall = 1'b0; fif.if_ready = 1'b1;
    for (int i = 0; i < 20 && m_ph != 2; i++) cycle();
    if (m_ph != 2) begin
      n_tests++; n_fail++;
      $display("FAIL exec_timeout: phase %0d expected 2", m_ph);
    end
  endtask

  task automatic goto_pc(input logic [31:0] tgt);
    run_to_exec();
    npc_op = 3'd5;
    imm    = tgt - m_pc;
    cycle();
    run_to_exec();
  endtask

  typedef struct {
    logic [31:0] start_pc;
    logic [2:0]  op;
    logic [2:0]  flag;
    logic [31:0] off;
    logic [31:0] base;
    logic        exp_taken;
    logic [31:0] exp_next;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[$];

  initial begin
    fif.if_ready = 1'b0;
    vecs.push_back('{32'h10,       3'd1, 3'b001, 32'hFFFF_FFF8, 32'h0,      1'b1, 32'h08,   1'b0});
    vecs.push_back('{32'h10,       3'd1, 3'b100, 32'hFFFF_FFF8, 32'h0,      1'b0, 32'h14,   1'b0});
    vecs.push_back('{32'h20,       3'd4, 3'b001, 32'h40,        32'h0,      1'b1, 32'h60,   1'b0});
    vecs.push_back('{32'h20,       3'd3, 3'b100, 32'h40,        32'h0,      1'b0, 32'h24,   1'b0});
    vecs.push_back('{32'h20,       3'd6, 3'b000, 32'h0,         32'h1235,   1'b1, 32'h1234, 1'b0});
    vecs.push_back('{32'h20,       3'd2, 3'b011, 32'h8,         32'h0,      1'b1, 32'h28,   1'b0});
    vecs.push_back('{32'h20,       3'd4, 3'b011, 32'h8,         32'h0,      1'b0, 32'h24,   1'b0});
    vecs.push_back('{32'h20,       3'd7, 3'b001, 32'h8,         32'h0,      1'b0, 32'h24,   1'b0});
    vecs.push_back('{32'hFFFF_FFFC, 3'd0, 3'b001, 32'h8,        32'h0,      1'b0, 32'h0,    1'b0});
    vecs.push_back('{32'h100,      3'd3, 3'b010, 32'hFFFF_FF00, 32'h0,      1'b1, 32'h0,    1'b0});
    vecs.push_back('{32'h40,       3'd5, 3'b000, 32'h6,         32'h0,      1'b1, 32'h40,   1'b1});
    vecs.push_back('{32'h40,       3'd6, 3'b000, 32'h0,         32'h1236,   1'b1, 32'h40,   1'b1});

    // Reset release and first instructions.
    assert_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    fif.if_ready = 1'b1;
    #1;
    chk("boot_idle_req", 32'(fif.if_req), 32'd0);
    chk("boot_pc_plus4", pc_plus4,        32'h4);
    cycle();
    chk("seq_addr0",  fif.if_addr,      32'h0);
    chk("seq_exec0",  32'(exec_valid),  32'd0);
    cycle();
    chk("seq_exec1",  32'(exec_valid),  32'd1);
    cycle();
    chk("seq_addr4",  fif.if_addr,      32'h4);
    cycle();
    cycle();
    chk("seq_addr8",  fif.if_addr,      32'h8);

    // Table-driven redirect checks.
    foreach (vecs[k]) begin
      if (m_mis) reset_cycle();
      goto_pc(vecs[k].start_pc);
      npc_op      = vecs[k].op;
      branch_flag = vecs[k].flag;
      imm         = vecs[k].off;
      jalr_base   = vecs[k].base;
      #1;
      chk($sformatf("vec%0d_taken", k), 32'(taken), 32'(vecs[k].exp_taken));
      cycle();
      chk($sformatf("vec%0d_mis", k), 32'(misalign), 32'(vecs[k].exp_mis));
      if (vecs[k].exp_mis) chk($sformatf("vec%0d_pc", k), pc, vecs[k].start_pc);
      else                 chk($sformatf("vec%0d_next", k), fif.if_addr, vecs[k].exp_next);
    end

    // Memory wait then stall: request and address stable, one PC update.
    reset_cycle();
    run_to_exec();
    npc_op = 3'd0;
    cycle();
    fif.if_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("wait_req",  32'(fif.if_req), 32'd1);
      chk("wait_addr", fif.if_addr,     32'h4);
    end
    fif.if_ready = 1'b1;
    cycle();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("stall_pc",   pc,               32'h4);
      chk("stall_exec", 32'(exec_valid),  32'd1);
    end
    stall = 1'b0;
    cycle();
    chk("stall_release_pc", pc, 32'h8);

    // Misaligned JAL halts; asynchronous reset recovers.
    goto_pc(32'h40);
    npc_op = 3'd5;
    imm    = 32'h6;
    cycle();
    npc_op = 3'd0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      chk("halt_req", 32'(fif.if_req), 32'd0);
      chk("halt_pc",  pc,              32'h40);
      chk("halt_mis", 32'(misalign),   32'd1);
    end
    assert_reset();
    chk("halt_rst_pc",  pc,            RST_PC);
    chk("halt_rst_mis", 32'(misalign), 32'd0);
    cycle();
    rst_n = 1'b1;

    // Reset asserted in FETCH while memory answers: no EXEC entry.
    cycle();
    chk("midfetch_req", 32'(fif.if_req), 32'd1);
    fif.if_ready = 1'b1;
    assert_reset();
    cycle();
    chk("midfetch_exec", 32'(exec_valid), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("midfetch_boot", 32'(fif.if_req), 32'd0);
    cycle();
    chk("midfetch_fetch", 32'(fif.if_req), 32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      fif.if_ready = ($urandom_range(0, 3) != 0);
      stall        = ($urandom_range(0, 4) == 0);
      npc_op       = 3'($urandom);
      branch_flag  = 3'($urandom);
      imm          = ($urandom_range(0, 5) == 0) ? $urandom : ($urandom & 32'h0000_0FFC);
      jalr_base    = $urandom;
      if (m_ph == 3 && $urandom_range(0, 3) == 0) reset_cycle();
      else cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
